// File: rtl/led_breather.sv
// Breathing brightness sequencer for the LED PWM dimmer.
// Ramps the duty up, holds, ramps down, holds, and accepts a manual duty override.
module led_breather #(
  parameter int DW          = 8,
  parameter int STEP_CYCLES = 65536,
  parameter int HOLD_CYCLES = 4194304,
  parameter int DUTY_MIN    = 0,
  parameter int DUTY_MAX    = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic          i_set_stb,
  input  logic [DW-1:0] i_set_duty,
  output logic [DW-1:0] o_duty,
  output logic          o_stb,
  output logic [2:0]    o_state
);

  localparam int TMAX = (STEP_CYCLES > HOLD_CYCLES) ? STEP_CYCLES : HOLD_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] MIN_V     = DW'(DUTY_MIN);
  localparam logic [DW-1:0] MAX_V     = DW'(DUTY_MAX);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RAMP_UP   = 3'd1;
  localparam logic [2:0] S_HOLD_HIGH = 3'd2;
  localparam logic [2:0] S_RAMP_DOWN = 3'd3;
  localparam logic [2:0] S_HOLD_LOW  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic          stb_q, stb_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] set_clamped;
  int            set_val;

  // Compare in int so the clamp bounds never fold into constant unsigned tests.
  always_comb begin
    set_val = int'(i_set_duty);
    if (set_val < DUTY_MIN)
      set_clamped = MIN_V;
    else if (set_val > DUTY_MAX)
      set_clamped = MAX_V;
    else
      set_clamped = i_set_duty;
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    stb_d   = 1'b0;
    timer_d = timer_q;
    if (i_set_stb) begin
      duty_d  = set_clamped;
      stb_d   = 1'b1;
      timer_d = STEP_LOAD;
      if (i_en)
        state_d = (set_clamped < MAX_V) ? S_RAMP_UP : S_RAMP_DOWN;
      else
        state_d = S_IDLE;
    end else if (!i_en) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = (duty_q < MAX_V) ? S_RAMP_UP : S_RAMP_DOWN;
          timer_d = STEP_LOAD;
        end
        S_RAMP_UP: begin
          if (timer_q == '0) begin
            if (duty_q < MAX_V)
              duty_d = duty_q + 1'b1;
            stb_d = 1'b1;
            if (duty_d >= MAX_V) begin
              state_d = S_HOLD_HIGH;
              timer_d = HOLD_LOAD;
            end else begin
              timer_d = STEP_LOAD;
            end
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_HOLD_HIGH: begin
          if (timer_q == '0) begin
            state_d = S_RAMP_DOWN;
            timer_d = STEP_LOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_RAMP_DOWN: begin
          if (timer_q == '0) begin
            if (duty_q > MIN_V)
              duty_d = duty_q - 1'b1;
            stb_d = 1'b1;
            if (duty_d <= MIN_V) begin
              state_d = S_HOLD_LOW;
              timer_d = HOLD_LOAD;
            end else begin
              timer_d = STEP_LOAD;
            end
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_HOLD_LOW: begin
          if (timer_q == '0) begin
            state_d = S_RAMP_UP;
            timer_d = STEP_LOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      duty_q  <= MIN_V;
      stb_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      stb_q   <= stb_d;
      timer_q <= timer_d;
    end
  end

  assign o_duty  = duty_q;
  assign o_stb   = stb_q;
  assign o_state = state_q;

endmodule

// File: doc/led_breather.md
Name: led_breather

Overview:
Brightness sequencer that sits directly upstream of the LED PWM dimmer stage. It generates a "breathing" duty-cycle value: the duty ramps up, holds at the top, ramps down, holds at the bottom, and repeats. It also accepts a manual duty override. The PWM stage compares o_duty against its free-running counter, and o_stb marks every duty change for any downstream consumer that needs one.

Parameters:
DW, 8, duty width in bits; matches the PWM compare width.
STEP_CYCLES, 65536, clocks between successive one-LSB duty steps while ramping; must be >= 1.
HOLD_CYCLES, 4194304, clocks spent in each hold state; must be >= 1.
DUTY_MIN, 0, lower ramp limit; must satisfy DUTY_MIN < DUTY_MAX.
DUTY_MAX, 255, upper ramp limit; must satisfy DUTY_MAX <= 2^DW-1.

Ports:
i_clk  input  1  system clock; all state updates on its rising edge.
i_reset  input  1  asynchronous, active-high reset.
i_en  input  1  level; 1 = run the breathing sequence, 0 = freeze the duty.
i_set_stb  input  1  single-cycle request to load i_set_duty.
i_set_duty  input  DW  manual duty value, sampled when i_set_stb=1.
o_duty  output  DW  current duty value, registered.
o_stb  output  1  one-cycle pulse on the cycle o_duty takes a new value.
o_state  output  3  current FSM state: IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4.

Behaviour:
- Reset (asynchronous, active-high): o_duty=DUTY_MIN, o_stb=0, o_state=IDLE, timer=0. Asserting reset mid-ramp clears all state immediately, with no clock edge required. After release, the block waits in IDLE.
- Timer: a down-counter wide enough for max(STEP_CYCLES, HOLD_CYCLES)-1.
  - Loaded with STEP_CYCLES-1 on entry to a ramp state and after each step.
  - Loaded with HOLD_CYCLES-1 on entry to a hold state.
  - A step or hold expiry fires on the cycle the timer is 0.
- IDLE:
  - o_duty holds its value.
  - If i_en=1, the next state is RAMP_UP when o_duty < DUTY_MAX, otherwise RAMP_DOWN. The timer is loaded with STEP_CYCLES-1.
- RAMP_UP: on timer==0, o_duty <= o_duty+1 and o_stb=1.
  - If the new value equals DUTY_MAX, go to HOLD_HIGH in the same cycle.
  - Otherwise, reload the step timer.
- HOLD_HIGH: on timer==0, go to RAMP_DOWN and load the step timer. o_duty is unchanged.
- RAMP_DOWN: mirror of RAMP_UP. o_duty <= o_duty-1; reaching DUTY_MIN goes to HOLD_LOW.
- HOLD_LOW: on timer==0, go to RAMP_UP and load the step timer.
- Latency: the first step occurs exactly STEP_CYCLES clocks after the cycle in which the ramp state is entered.
- No wrap-around: o_duty never leaves [DUTY_MIN, DUTY_MAX], and arithmetic saturates at the limits.
- i_en=0 in any non-IDLE state:
  - Next state is IDLE.
  - o_duty frozen and no o_stb.
  - Timer contents discarded.
- i_set_stb=1 has the highest priority and beats a simultaneous step or expiry in the same cycle.
  - o_duty <= clamp(i_set_duty, DUTY_MIN, DUTY_MAX); o_stb=1, even if the value is unchanged.
  - Timer loaded with STEP_CYCLES-1.
  - If i_en=1, next state is RAMP_UP when the clamped value < DUTY_MAX, else RAMP_DOWN.
  - If i_en=0, next state is IDLE.
- o_stb is never high on two consecutive cycles unless i_set_stb is asserted on consecutive cycles or STEP_CYCLES=1.
- Full sequence period: 2*(DUTY_MAX-DUTY_MIN)*STEP_CYCLES + 2*HOLD_CYCLES clocks.

Test Plan:
- Params DW=8, STEP_CYCLES=4, HOLD_CYCLES=3, MIN=0, MAX=5. Reset, then i_en=1 continuously:
  - o_duty steps 0->1->...->5, 4 clocks apart; o_stb pulses 5 times.
  - o_state=HOLD_HIGH for 3 clocks, then ramps 5->0.
  - Period = 46 clocks, checked over 3 periods.
- Assert i_reset asynchronously (between edges) mid-RAMP_DOWN at duty 3 -> o_duty=0, o_state=0, o_stb=0 immediately, before the next edge.
- Drop i_en at duty 2 during RAMP_UP for 10 clocks -> o_state=IDLE, o_duty stays 2, no o_stb. Re-enable -> 3 appears exactly 5 clocks after the i_en rise (1 to enter RAMP_UP, then 4).
- i_set_stb with i_set_duty=200 (MAX=5) -> o_duty=5 and o_stb=1 the next cycle, then RAMP_DOWN. i_set_duty=5 while at 5 -> o_stb still pulses.
- i_set_stb=1 on the same cycle the step timer hits 0 in RAMP_UP at duty 3 with i_set_duty=1 -> o_duty=1, not 4; a single o_stb; state RAMP_UP.
- STEP_CYCLES=1, HOLD_CYCLES=1 -> o_duty changes every clock during ramps, each hold lasts 1 clock, and o_duty never exceeds 5 or goes below 0.
